// File: rtl/cmp_share_arbiter_pkg.sv
// Shared types and helpers for the shared-comparator arbiter.
package cmp_arb_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_res_t;

    // Next index in round-robin order, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Requester-side bus of the shared comparator: packed requests/operands in, grant/ack/result out.
interface cmp_share_arbiter_if
    import cmp_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       ack;
    logic                  res_gt;
    logic                  res_lt;
    logic                  res_eq;
    logic                  busy;

    modport master (
        output req, op_a, op_b,
        input  grant, ack, res_gt, res_lt, res_eq, busy
    );

    modport slave (
        input  req, op_a, op_b,
        output grant, ack, res_gt, res_lt, res_eq, busy
    );
endinterface

// File: rtl/cmp_share_arbiter_mag_cmp_core.sv
// Combinational WIDTH-bit magnitude comparator.
// CMP_SIGNED_EN selects two's-complement compare; otherwise unsigned.
module mag_cmp_core
    import cmp_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output cmp_res_t         o_res_c
);

`ifdef CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement onto unsigned ordering.
    localparam logic [WIDTH-1:0] SIGN_FLIP = WIDTH'(1) << (WIDTH - 1);
`else
    localparam logic [WIDTH-1:0] SIGN_FLIP = '0;
`endif

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    assign w_a = i_a ^ SIGN_FLIP;
    assign w_b = i_b ^ SIGN_FLIP;

    assign o_res_c.gt = (w_a > w_b);
    assign o_res_c.lt = (w_a < w_b);
    assign o_res_c.eq = (w_a == w_b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters.
// Optional two's-complement compare via CMP_SIGNED_EN (see mag_cmp_core).
module cmp_share_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ
) (
    input  logic                clk,
    input  logic                rst_n,
    cmp_share_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    state_e           r_state;
    state_e           w_next_state;
    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  w_grant_d;
    logic [NREQ-1:0]  r_ack;
    logic [NREQ-1:0]  w_ack_d;
    cmp_res_t         r_res;
    cmp_res_t         w_res_d;
    cmp_res_t         w_cmp;
    logic             r_busy;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_d;
    logic [PTR_W-1:0] w_win;
    logic             w_found;
    logic             w_load;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;

    // Winner: first requester after r_ptr in circular order.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_win   = r_ptr;
        idx     = 32'(r_ptr);
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = rr_next(idx, NREQ);
            if (!w_found && bus.req[PTR_W'(idx)]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(idx);
            end
        end
    end

    mag_cmp_core #(.WIDTH(WIDTH)) u_core (
        .i_a     (r_op_a),
        .i_b     (r_op_b),
        .o_res_c (w_cmp)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = '0;
        w_ack_d      = '0;
        w_res_d      = r_res;
        w_ptr_d      = r_ptr;
        w_load       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = CMP;
                    w_grant_d    = NREQ'(1) << w_win;
                    w_ptr_d      = w_win;
                    w_load       = 1'b1;
                end
            end
            CMP: begin
                w_next_state = DONE;
                w_res_d      = w_cmp;
                w_ack_d      = NREQ'(1) << r_ptr;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_ack   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= PTR_W'(NREQ - 1);
            r_op_a  <= '0;
            r_op_b  <= '0;
        end else begin
            r_grant <= w_grant_d;
            r_ack   <= w_ack_d;
            r_res   <= w_res_d;
            r_busy  <= (w_next_state != IDLE);
            r_ptr   <= w_ptr_d;
            if (w_load) begin
                r_op_a <= bus.op_a[32'(w_win) * WIDTH +: WIDTH];
                r_op_b <= bus.op_b[32'(w_win) * WIDTH +: WIDTH];
            end
        end
    end

    assign bus.grant  = r_grant;
    assign bus.ack    = r_ack;
    assign bus.res_gt = r_res.gt;
    assign bus.res_lt = r_res.lt;
    assign bus.res_eq = r_res.eq;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: directed requests push expected acks, a monitor pops and checks.
module tb_cmp_share_arbiter;
    import cmp_arb_pkg::*;

    localparam int unsigned W = DEF_WIDTH;
    localparam int unsigned N = DEF_NREQ;
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    typedef struct {
        int         idx;
        logic [2:0] res;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   exp_u;
        logic [2:0]   exp_s;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    exp_t sb[$];
    int   ack_cyc[$];

    cmp_share_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    cmp_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int idx, input logic [2:0] r);
        exp_t e;
        e.idx = idx;
        e.res = r;
        sb.push_back(e);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_a[i*W +: W] = a;
        bus.op_b[i*W +: W] = b;
    endtask

    // Returns at the posedge following the target ack (the edge leaving DONE).
    task automatic wait_acks(input int target, input int budget);
        int n = 0;
        while (ack_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (ack_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", ack_cnt, target);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every ack must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.ack != '0) begin
            ack_cyc.push_back(cyc);
            ack_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=%b expected none", bus.ack);
            end else begin
                e = sb.pop_front();
                chk("ack_onehot", int'(bus.ack), 1 << e.idx);
                chk("result_gt_lt_eq", int'({bus.res_gt, bus.res_lt, bus.res_eq}), int'(e.res));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   start;
        int   t0;
        vec_t vecs[5];

        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_ack", int'(bus.ack), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_res", int'({bus.res_gt, bus.res_lt, bus.res_eq}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request, latency and result
        set_ops(0, 4'd9, 4'd5);
        push(0, GT);
        base = ack_cyc.size();
        start = ack_cnt;
        t0 = cyc;
        bus.req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        chk("t1_grant", int'(bus.grant), 1);
        chk("t1_busy", int'(bus.busy), 1);
        chk("t1_ack_early", int'(bus.ack), 0);
        wait_acks(start + 1, 10);
        #1 bus.req = '0;
        if (ack_cyc.size() > base) chk("t1_latency", ack_cyc[base] - t0, 2);
        @(negedge clk);
        chk("t1_ack_dropped", int'(bus.ack), 0);
        chk("t1_idle_busy", int'(bus.busy), 0);

        // All four requesting equal operands: rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 4'd3, 4'd3);
        push(0, EQ); push(1, EQ); push(2, EQ); push(3, EQ); push(0, EQ);
        base = ack_cyc.size();
        start = ack_cnt;
        bus.req = 4'b1111;
        wait_acks(start + 5, 40);
        #1 bus.req = '0;
        for (int k = 1; k < 5; k++)
            if (ack_cyc.size() > base + k)
                chk("t2_spacing", ack_cyc[base+k] - ack_cyc[base+k-1], 3);

        // Requester 2 holds req through DONE: no duplicate, next ack 3 cycles later
        set_ops(2, 4'd2, 4'd14);
        push(2, LT); push(2, LT);
        base = ack_cyc.size();
        start = ack_cnt;
        bus.req = 4'b0100;
        wait_acks(start + 2, 20);
        #1 bus.req = '0;
        if (ack_cyc.size() > base + 1) chk("t3_spacing", ack_cyc[base+1] - ack_cyc[base], 3);

        // Reset during CMP abandons the operation and restarts rotation at 0
        do_reset();
        set_ops(1, 4'd1, 4'd1);
        bus.req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        chk("t4_grant_before_rst", int'(bus.grant), 2);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_grant", int'(bus.grant), 0);
        chk("t4_rst_ack", int'(bus.ack), 0);
        chk("t4_rst_busy", int'(bus.busy), 0);
        bus.req = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_ops(0, 4'd5, 4'd6);
        set_ops(1, 4'd7, 4'd2);
        push(0, LT); push(1, GT);
        start = ack_cnt;
        bus.req = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        chk("t4_first_grant", int'(bus.grant), 1);
        wait_acks(start + 1, 10);
        #1 bus.req = 4'b0010;
        wait_acks(start + 2, 10);
        #1 bus.req = '0;

        // Operand change after latch is ignored
        set_ops(0, 4'd4, 4'd8);
        push(0, LT);
        start = ack_cnt;
        bus.req = 4'b0001;
        @(posedge clk);
        #1 set_ops(0, 4'd12, 4'd8);
        wait_acks(start + 1, 10);
        #1 bus.req = '0;

        // Sign handling of MSB
        set_ops(3, 4'b1000, 4'b0111);
`ifdef CMP_SIGNED_EN
        push(3, LT);
`else
        push(3, GT);
`endif
        start = ack_cnt;
        bus.req = 4'b1000;
        wait_acks(start + 1, 10);
        #1 bus.req = '0;

        // Boundary operands on requester 1
        vecs[0] = '{a: 4'd15, b: 4'd15, exp_u: EQ, exp_s: EQ};
        vecs[1] = '{a: 4'd0,  b: 4'd15, exp_u: LT, exp_s: GT};
        vecs[2] = '{a: 4'd15, b: 4'd0,  exp_u: GT, exp_s: LT};
        vecs[3] = '{a: 4'd0,  b: 4'd0,  exp_u: EQ, exp_s: EQ};
        vecs[4] = '{a: 4'd7,  b: 4'd8,  exp_u: LT, exp_s: GT};
        foreach (vecs[v]) begin
            set_ops(1, vecs[v].a, vecs[v].b);
`ifdef CMP_SIGNED_EN
            push(1, vecs[v].exp_s);
`else
            push(1, vecs[v].exp_u);
`endif
            start = ack_cnt;
            bus.req = 4'b0010;
            wait_acks(start + 1, 10);
            #1 bus.req = '0;
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("final_busy", int'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
- Shares one combinational N-bit magnitude comparator among NREQ requesters.
- Round-robin arbitration; the granted requester's operands are latched; the registered gt/lt/eq result is returned with a one-cycle one-hot ack.
- Sits between several datapath clients (sorters, limit checkers) and a single comparator instance, saving area over per-client comparators.

Parameters:
- WIDTH, 4, operand width in bits (>=1).
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request; held high until the matching ack.
- op_a  input  NREQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- op_b  input  NREQ*WIDTH  packed operand B, same packing.
- grant  output  NREQ  one-hot; high while the requester's operation is in flight.
- ack  output  NREQ  one-hot, one-cycle pulse; result valid this cycle.
- res_gt  output  1  A > B for the acked operation.
- res_lt  output  1  A < B.
- res_eq  output  1  A == B.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; grant, ack, res_gt, res_lt, res_eq, busy all 0; operand registers 0; rr_ptr = NREQ-1 so requester 0 wins first.
- FSM states: IDLE, CMP, DONE. All outputs are registered.
- IDLE:
  - At the edge where req != 0: select the winner, latch op_a/op_b slices, set grant[winner]=1, set rr_ptr=winner, go to CMP.
  - If req == 0, stay in IDLE.
- Winner selection: first set bit of req scanning indices rr_ptr+1, rr_ptr+2, ... modulo NREQ.
- CMP:
  - The comparator evaluates the latched operands.
  - At the next edge: register gt/lt/eq, set ack[winner]=1, clear grant, go to DONE.
- DONE:
  - ack and results are visible for exactly this cycle.
  - At the next edge: clear ack, go to IDLE.
  - res_* hold their last value after ack drops; they are meaningful only while ack is high.
- Latency: req sampled at edge E0 -> ack high between E1 and E2. Back-to-back throughput is one operation per 3 cycles.
- Requesters drop req after seeing ack. req is ignored in CMP and DONE, so a req still high during DONE does not cause a double grant. A re-asserted req is sampled at the first IDLE edge.
- req of the granted requester dropping during CMP: the result is still produced and ack still pulses. Operands changing after latch have no effect.
- Simultaneous requests: exactly one winner per round. Starvation-free: a continuously requesting client waits at most NREQ-1 rounds.
- Exactly one of res_gt/res_lt/res_eq is 1 whenever ack != 0.
- Width rule: unsigned compare over WIDTH bits, no extension.
- Reset mid-operation: the operation is abandoned, no ack is issued, and rr_ptr returns to NREQ-1.

Optional Feature:
- Macro: CMP_SIGNED_EN.
- Defined: operands are two's complement. The comparator treats the MSB as the sign bit, equivalent to inverting the MSB of both operands before the unsigned compare.
- Undefined: unsigned compare only.
- Arbitration and timing are identical in both cases.

Decomposition:
- Package cmp_arb_pkg holds:
  - state typedef enum {IDLE, CMP, DONE};
  - default WIDTH/NREQ localparams;
  - a result struct {gt, lt, eq};
  - a round-robin next-index function.
- Sub-module mag_cmp_core: purely combinational, parameterized WIDTH, outputs gt/lt/eq.
  - It contains the CMP_SIGNED_EN ifdef.
  - It is instantiated once in cmp_share_arbiter.

Test Plan:
- Reset then req=0001, op_a[0]=9, op_b[0]=5 -> grant=0001 after E0; at E1 ack=0001, res_gt=1, res_lt=0, res_eq=0; ack=0 after E2.
- req=1111, all pairs 3/3 held continuously -> ack order 0,1,2,3,0, one ack every 3 cycles; each ack has res_eq=1.
- Requester 2 only, op_a=2, op_b=14; req held high through DONE -> no duplicate ack in DONE; second ack arrives exactly 3 cycles after the first.
- Assert rst_n=0 during CMP for requester 1 -> grant, ack, busy go to 0 immediately; after release, req=0011 grants requester 0 first.
- Change op_a[0] from 4 to 12 one cycle after grant, with op_b[0]=8 -> result uses the latched 4: res_lt=1.
- With CMP_SIGNED_EN defined: op_a=4'b1000 (-8), op_b=4'b0111 (7) -> res_lt=1. Undefined: same stimulus -> res_gt=1.
